mbist_addr_scan_ctrl: RTL

Serial scan master for the MBIST address generator's start/end address chain. It takes a parallel start/end address pair from the configuration side and shifts it into the generator's chain, driving `scan_shift`, `sdi` and `scan_load`. It captures the previous chain contents from `sdo` for readback. A read-only mode recirculates the chain so the old contents can be read without being changed. The block sits between the MBIST register/configuration logic and one or more address generators.

---
 rtl/mbist_addr_scan_ctrl_if.sv | 30 +++
 rtl/mbist_addr_scan_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/mbist_addr_scan_ctrl_if.sv
// Bundle between the MBIST configuration side, the address scan master and the
// address generator's start/end chain.
// Ports: cfg_* request/ack and readback (config side), scan_* / sdi / sdo (chain side).
// Modport master is the scan controller; slave is the config logic plus generator.
interface mbist_addr_scan_ctrl_if #(
  parameter int BIST_ADDR_WD = 9
);
  logic                    cfg_req;
  logic                    cfg_rd_only;
  logic [BIST_ADDR_WD-1:0] cfg_start_addr;
  logic [BIST_ADDR_WD-1:0] cfg_end_addr;
  logic                    cfg_ack;
  logic                    busy;
  logic [BIST_ADDR_WD-1:0] rd_start_addr;
  logic [BIST_ADDR_WD-1:0] rd_end_addr;
  logic                    scan_shift;
  logic                    scan_load;
  logic                    sdi;
  logic                    sdo;

  modport master (
    input  cfg_req, cfg_rd_only, cfg_start_addr, cfg_end_addr, sdo,
    output cfg_ack, busy, rd_start_addr, rd_end_addr, scan_shift, scan_load, sdi
  );

  modport slave (
    output cfg_req, cfg_rd_only, cfg_start_addr, cfg_end_addr, sdo,
    input  cfg_ack, busy, rd_start_addr, rd_end_addr, scan_shift, scan_load, sdi
  );
endinterface

// File: rtl/mbist_addr_scan_ctrl.sv
// Serial scan master: shifts a {start,end} address pair into the generator chain
// LSB first while capturing the old contents from sdo; optional read-only recirculate.
// Ports: clk, rst_n (async active-low), bus (master modport: cfg_*, rd_*, scan_*, sdi, sdo).
module mbist_addr_scan_ctrl #(
  parameter int BIST_ADDR_WD = 9,
  parameter int CNT_WD       = $clog2(2*BIST_ADDR_WD+1)
) (
  input logic                    clk,
  input logic                    rst_n,
  mbist_addr_scan_ctrl_if.master bus
);

  localparam int                CHAIN_LEN = 2*BIST_ADDR_WD;
  localparam logic [CNT_WD-1:0] LAST_CNT  = CNT_WD'(CHAIN_LEN-1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CHAIN_LEN-1:0]    tx_q, tx_d;
  logic [CHAIN_LEN-1:0]    rx_q, rx_d;
  logic                    rd_only_q, rd_only_d;
  logic [CNT_WD-1:0]       cnt_q, cnt_d;
  logic [BIST_ADDR_WD-1:0] rd_start_q, rd_start_d;
  logic [BIST_ADDR_WD-1:0] rd_end_q, rd_end_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      rd_only_q  <= 1'b0;
      cnt_q      <= '0;
      rd_start_q <= '0;
      rd_end_q   <= '0;
    end else begin
      state      <= state_nxt;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rd_only_q  <= rd_only_d;
      cnt_q      <= cnt_d;
      rd_start_q <= rd_start_d;
      rd_end_q   <= rd_end_d;
    end
  end

  always_comb begin
    state_nxt  = state;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_only_d  = rd_only_q;
    cnt_d      = cnt_q;
    rd_start_d = rd_start_q;
    rd_end_d   = rd_end_q;
    case (state)
      IDLE: begin
        if (bus.cfg_req) begin
          tx_d      = {bus.cfg_start_addr, bus.cfg_end_addr};
          rd_only_d = bus.cfg_rd_only;
          cnt_d     = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        tx_d  = tx_q >> 1;
        // Oldest chain bit (old end_addr[0]) ends up at rx[0] after the last shift.
        rx_d  = {bus.sdo, rx_q[CHAIN_LEN-1:1]};
        cnt_d = cnt_q + CNT_WD'(1);
        if (cnt_q == LAST_CNT) begin
          if (rd_only_q) begin
            // Readback is registered on the edge entering DONE so it is
            // valid in the same cycle as cfg_ack; the final sdo bit is in rx_d.
            state_nxt  = DONE;
            rd_start_d = rx_d[CHAIN_LEN-1:BIST_ADDR_WD];
            rd_end_d   = rx_d[BIST_ADDR_WD-1:0];
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        state_nxt  = DONE;
        rd_start_d = rx_q[CHAIN_LEN-1:BIST_ADDR_WD];
        rd_end_d   = rx_q[BIST_ADDR_WD-1:0];
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Scan outputs are decoded from state only; cfg_req never reaches them
  // combinationally. In read-only mode sdo loops back to sdi while shifting.
  assign bus.scan_shift    = (state == SHIFT);
  assign bus.scan_load     = (state == LOAD);
  assign bus.cfg_ack       = (state == DONE);
  assign bus.busy          = (state != IDLE);
  assign bus.sdi           = (state == SHIFT) && (rd_only_q ? bus.sdo : tx_q[0]);
  assign bus.rd_start_addr = rd_start_q;
  assign bus.rd_end_addr   = rd_end_q;

endmodule
